// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// Module : i2c_pkg
// Brief  : Shared state encodings and defaults for the I2C SCL generator.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam int MIN_HALF     = 2;
    localparam int DEF_DIV_W    = 6;
    localparam int DEF_RST_HALF = 50;

endpackage

`default_nettype wire

// File: rtl/i2c_sync2.sv
// ---------------------------------------------------------------------------
// Module : i2c_sync2
// Brief  : Two-flop synchroniser for the SCL pad readback, resets to released (1).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_scl_gen.sv
// ---------------------------------------------------------------------------
// Module : i2c_scl_gen
// Brief  : I2C SCL generator with programmable half-period, run control and
//          mid-low / mid-high phase ticks. Optional clock stretching is
//          enabled by defining I2C_SCL_STRETCH_EN.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int RST_HALF = DEF_RST_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] half_period,
    input  logic             scl_in,
    output logic             scl_out,
    output logic             busy,
    output logic             scl_rise,
    output logic             scl_fall,
    output logic             drive_tick,
    output logic             sample_tick,
    output logic             stretching
);

    logic [1:0]       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] hp_q;

    logic [1:0]       nxt_state;
    logic [DIV_W-1:0] nxt_cnt;
    logic [DIV_W-1:0] nxt_hp;
    logic             nxt_scl;
    logic             nxt_rise;
    logic             nxt_fall;
    logic [DIV_W-1:0] hp_eff;
    logic             last;
    logic             stall;

    assign hp_eff = (half_period < DIV_W'(MIN_HALF)) ? DIV_W'(MIN_HALF) : half_period;
    assign last   = (cnt == hp_q - DIV_W'(1));

`ifdef I2C_SCL_STRETCH_EN
    logic scl_s;

    i2c_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (scl_in),
        .q   (scl_s)
    );

    // A slave may only hold SCL low at the very start of the high phase.
    assign stall = (state == ST_HIGH) && (cnt == '0) && !scl_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            stretching <= 1'b0;
        end else begin
            stretching <= stall;
        end
    end
`else
    logic unused_scl_in;

    assign unused_scl_in = scl_in;
    assign stall         = 1'b0;
    assign stretching    = 1'b0;
`endif

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_hp    = hp_q;
        nxt_scl   = scl_out;
        nxt_rise  = 1'b0;
        nxt_fall  = 1'b0;
        case (state)
            ST_IDLE: begin
                nxt_cnt = '0;
                nxt_scl = 1'b1;
                if (en) begin
                    nxt_state = ST_HIGH;
                    nxt_hp    = hp_eff;
                end
            end
            ST_HIGH: begin
                if (stall) begin
                    nxt_cnt = cnt;
                end else if (last) begin
                    nxt_cnt = '0;
                    nxt_hp  = hp_eff;
                    if (en) begin
                        nxt_state = ST_LOW;
                        nxt_scl   = 1'b0;
                        nxt_fall  = 1'b1;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end else begin
                    nxt_cnt = cnt + DIV_W'(1);
                end
            end
            ST_LOW: begin
                if (last) begin
                    nxt_cnt   = '0;
                    nxt_hp    = hp_eff;
                    nxt_state = ST_HIGH;
                    nxt_scl   = 1'b1;
                    nxt_rise  = 1'b1;
                end else begin
                    nxt_cnt = cnt + DIV_W'(1);
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
                nxt_scl   = 1'b1;
            end
        endcase
    end

    // Ticks decode the next-cycle state so they line up with the registered cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hp_q        <= DIV_W'(RST_HALF);
            scl_out     <= 1'b1;
            busy        <= 1'b0;
            scl_rise    <= 1'b0;
            scl_fall    <= 1'b0;
            drive_tick  <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            hp_q        <= nxt_hp;
            scl_out     <= nxt_scl;
            busy        <= (nxt_state != ST_IDLE);
            scl_rise    <= nxt_rise;
            scl_fall    <= nxt_fall;
            drive_tick  <= (nxt_state == ST_LOW)  && (nxt_cnt == (nxt_hp >> 1));
            sample_tick <= (nxt_state == ST_HIGH) && (nxt_cnt == (nxt_hp >> 1));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_scl_gen.sv
// ---------------------------------------------------------------------------
// Module : tb_i2c_scl_gen
// Brief  : Directed self-checking bench for i2c_scl_gen (default build).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i2c_scl_gen;

    localparam int DIV_W = 6;

    logic             clk;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] half_period;
    logic             scl_in;
    logic             scl_out;
    logic             busy;
    logic             scl_rise;
    logic             scl_fall;
    logic             drive_tick;
    logic             sample_tick;
    logic             stretching;

    int vectors = 0;
    int errors  = 0;

    // Monitor state: position within the current level, tick positions, pulse counts.
    int  pos         = 0;
    int  sample_pos  = -1;
    int  drive_pos   = -1;
    int  rise_cnt    = 0;
    int  fall_cnt    = 0;
    logic prev_scl   = 1'b1;
    logic prev_busy  = 1'b0;

    i2c_scl_gen #(.DIV_W(DIV_W), .RST_HALF(50)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .half_period (half_period),
        .scl_in      (scl_in),
        .scl_out     (scl_out),
        .busy        (busy),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .drive_tick  (drive_tick),
        .sample_tick (sample_tick),
        .stretching  (stretching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if ((scl_out != prev_scl) || (busy && !prev_busy)) pos = 0;
        else pos = pos + 1;
        prev_scl  = scl_out;
        prev_busy = busy;
        if (sample_tick) sample_pos = pos;
        if (drive_tick)  drive_pos  = pos;
        if (scl_rise)    rise_cnt   = rise_cnt + 1;
        if (scl_fall)    fall_cnt   = fall_cnt + 1;
    end

    // Counts negedges for which scl_out holds its current level (bounded).
    task automatic phase_len(output int len);
        logic lvl;
        lvl = scl_out;
        len = 0;
        while (scl_out == lvl && len < 1000) begin
            len = len + 1;
            @(negedge clk);
        end
    endtask

    task automatic busy_len(output int len);
        len = 0;
        while (busy && len < 1000) begin
            len = len + 1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (scl_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: scl_out=%b busy=%b, want scl_out=1 busy=0", scl_out, busy);
        end
        vectors++;
        if ({scl_rise, scl_fall, drive_tick, sample_tick, stretching} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b, want 00000",
                     {scl_rise, scl_fall, drive_tick, sample_tick, stretching});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || scl_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: busy=%b scl_out=%b, want 0/1", busy, scl_out);
        end
    endtask

    task automatic test_run_h50;
        int len;
        half_period = 6'd50;
        en          = 1'b1;
        rise_cnt    = 0;
        fall_cnt    = 0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || scl_out !== 1'b1) begin
            errors++;
            $display("FAIL start_state: busy=%b scl_out=%b, want 1/1", busy, scl_out);
        end
        for (int p = 0; p < 2; p++) begin
            phase_len(len);
            vectors++;
            if (len !== 50) begin
                errors++;
                $display("FAIL high_len[%0d]: got %0d cycles, want 50", p, len);
            end
            vectors++;
            if (scl_fall !== 1'b1 || sample_pos !== 25) begin
                errors++;
                $display("FAIL fall_sample[%0d]: scl_fall=%b sample_pos=%0d, want 1/25", p, scl_fall, sample_pos);
            end
            phase_len(len);
            vectors++;
            if (len !== 50) begin
                errors++;
                $display("FAIL low_len[%0d]: got %0d cycles, want 50", p, len);
            end
            vectors++;
            if (scl_rise !== 1'b1 || drive_pos !== 25) begin
                errors++;
                $display("FAIL rise_drive[%0d]: scl_rise=%b drive_pos=%0d, want 1/25", p, scl_rise, drive_pos);
            end
        end
        vectors++;
        if (rise_cnt !== 2 || fall_cnt !== 2 || stretching !== 1'b0) begin
            errors++;
            $display("FAIL pulse_count: rise=%0d fall=%0d stretching=%b, want 2/2/0", rise_cnt, fall_cnt, stretching);
        end
    endtask

    // Entered at the first cycle of a HIGH phase with en=1, H=50.
    task automatic test_stop_mid_low;
        int len;
        phase_len(len);
        repeat (10) @(negedge clk);
        en = 1'b0;
        phase_len(len);
        vectors++;
        if (len !== 40) begin
            errors++;
            $display("FAIL stop_low_rest: got %0d cycles, want 40", len);
        end
        busy_len(len);
        vectors++;
        if (len !== 50) begin
            errors++;
            $display("FAIL stop_final_high: got %0d busy cycles, want 50", len);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || scl_out !== 1'b1 || scl_fall !== 1'b0) begin
            errors++;
            $display("FAIL stop_parked: busy=%b scl_out=%b scl_fall=%b, want 0/1/0", busy, scl_out, scl_fall);
        end
    endtask

    task automatic test_half_period_change;
        int len;
        half_period = 6'd50;
        en          = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        half_period = 6'd10;
        en          = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        phase_len(len);
        vectors++;
        if (len !== 42) begin
            errors++;
            $display("FAIL hp_current_high: got %0d remaining cycles, want 42", len);
        end
        phase_len(len);
        vectors++;
        if (len !== 10) begin
            errors++;
            $display("FAIL hp_next_low: got %0d cycles, want 10", len);
        end
        half_period = 6'd0;
        phase_len(len);
        vectors++;
        if (len !== 10) begin
            errors++;
            $display("FAIL hp_high10: got %0d cycles, want 10", len);
        end
        phase_len(len);
        vectors++;
        if (len !== 2) begin
            errors++;
            $display("FAIL hp_zero_low: got %0d cycles, want 2", len);
        end
        half_period = 6'd1;
        phase_len(len);
        vectors++;
        if (len !== 2) begin
            errors++;
            $display("FAIL hp_zero_high: got %0d cycles, want 2", len);
        end
        phase_len(len);
        vectors++;
        if (len !== 2 || drive_pos !== 1) begin
            errors++;
            $display("FAIL hp_one_low: len=%0d drive_pos=%0d, want 2/1", len, drive_pos);
        end
        en = 1'b0;
        busy_len(len);
        vectors++;
        if (len !== 2 || scl_out !== 1'b1) begin
            errors++;
            $display("FAIL hp_stop: busy_len=%0d scl_out=%b, want 2/1", len, scl_out);
        end
    endtask

    task automatic test_reset_mid_low;
        int len;
        half_period = 6'd50;
        en          = 1'b1;
        @(negedge clk);
        phase_len(len);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (scl_out !== 1'b1 || busy !== 1'b0 ||
                {scl_rise, scl_fall, drive_tick, sample_tick} !== 4'b0) begin
                errors++;
                $display("FAIL reset_mid_low[%0d]: scl_out=%b busy=%b pulses=%b, want 1/0/0000", i, scl_out, busy,
                         {scl_rise, scl_fall, drive_tick, sample_tick});
            end
        end
        en  = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        half_period = 6'd50;
`ifdef I2C_SCL_STRETCH_EN
        scl_in      = 1'b1;
`else
        scl_in      = 1'b0;
`endif
        @(negedge clk);
        test_reset;
        test_run_h50;
        test_stop_mid_low;
        test_half_period_change;
        test_reset_mid_low;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
